// File: rtl/lnrv_ifu_flush_ctrl_if.sv
// IFU flush controller bus bundle.
// Commit-stage flush, fetch bus activity and PC redirect.
interface lnrv_ifu_flush_ctrl_if;
    logic        pipe_flush_req;
    logic        pipe_flush_ack;
    logic [31:0] pipe_flush_pc_op1;
    logic [31:0] pipe_flush_pc_op2;
    logic        fetch_cmd_fire;
    logic        fetch_rsp_fire;
    logic        fetch_credit;
    logic        rsp_discard;
    logic        pc_redirect_vld;
    logic        pc_redirect_rdy;
    logic [31:0] pc_redirect_pc;
    logic        flush_busy;

    modport master (
        output pipe_flush_req,
        input  pipe_flush_ack,
        output pipe_flush_pc_op1,
        output pipe_flush_pc_op2,
        output fetch_cmd_fire,
        output fetch_rsp_fire,
        input  fetch_credit,
        input  rsp_discard,
        input  pc_redirect_vld,
        output pc_redirect_rdy,
        input  pc_redirect_pc,
        input  flush_busy
    );

    modport slave (
        input  pipe_flush_req,
        output pipe_flush_ack,
        input  pipe_flush_pc_op1,
        input  pipe_flush_pc_op2,
        input  fetch_cmd_fire,
        input  fetch_rsp_fire,
        output fetch_credit,
        output rsp_discard,
        output pc_redirect_vld,
        input  pc_redirect_rdy,
        output pc_redirect_pc,
        output flush_busy
    );
endinterface

// File: rtl/lnrv_ifu_flush_ctrl.sv
// IFU flush controller: drains outstanding fetches,
// redirects the PC and acknowledges the commit-stage flush.
module lnrv_ifu_flush_ctrl #(
    parameter int OUTS_DEPTH = 4
) (
    input logic                    clk,
    input logic                    reset,
    lnrv_ifu_flush_ctrl_if.slave   bus
);
    localparam int CW = $clog2(OUTS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(OUTS_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_target;

    logic [31:0] w_sum;
    logic        w_cmd_only;
    logic        w_rsp_only;
    logic        w_full;
    logic        w_empty;
    logic        w_drained;

    assign w_sum      = bus.pipe_flush_pc_op1 + bus.pipe_flush_pc_op2;
    assign w_cmd_only = bus.fetch_cmd_fire & ~bus.fetch_rsp_fire;
    assign w_rsp_only = bus.fetch_rsp_fire & ~bus.fetch_cmd_fire;
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    // A stray command seen at count 0 must also drain first.
    assign w_drained  = w_empty & ~w_cmd_only;

    // Flush sequencing and target capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_target <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.pipe_flush_req) begin
                        r_target <= {w_sum[31:1], 1'b0};
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained)
                        r_state <= REDIR;
                end
                REDIR: begin
                    if (bus.pc_redirect_rdy)
                        r_state <= ACK;
                end
                ACK: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of fetches in flight on the bus.
    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (w_cmd_only && !w_full)
            r_count <= r_count + CW'(1);
        else if (w_rsp_only && !w_empty)
            r_count <= r_count - CW'(1);
    end

    assign bus.pipe_flush_ack  = (r_state == ACK);
    assign bus.pc_redirect_vld = (r_state == REDIR);
    assign bus.pc_redirect_pc  = r_target;
    assign bus.flush_busy      = (r_state != IDLE);
    assign bus.fetch_credit    = (r_state == IDLE) & (r_count < DEPTH_C);
    assign bus.rsp_discard     = (r_state == DRAIN) & bus.fetch_rsp_fire;

endmodule

// File: tb/tb_lnrv_ifu_flush_ctrl.sv
// Directed bench for lnrv_ifu_flush_ctrl.
// One record per clock cycle: inputs plus expected outputs.
module tb_lnrv_ifu_flush_ctrl;
    logic clk;
    logic reset;

    lnrv_ifu_flush_ctrl_if bus ();

    lnrv_ifu_flush_ctrl #(.OUTS_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        cmd;
        logic        rsp;
        logic        rdy;
        logic        e_ack;
        logic        e_cr;
        logic        e_dis;
        logic        e_vld;
        logic        e_busy;
        logic [31:0] e_pc;
    } vec_t;

    int n_cmp;
    int n_bad;
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic rq,
        input logic [31:0] a, input logic [31:0] b,
        input logic c, input logic r, input logic y,
        input logic ak, input logic cr, input logic ds,
        input logic vl, input logic bz, input logic [31:0] pc);
        vec_t v;
        v.rst = rs; v.req = rq; v.op1 = a; v.op2 = b;
        v.cmd = c; v.rsp = r; v.rdy = y;
        v.e_ack = ak; v.e_cr = cr; v.e_dis = ds;
        v.e_vld = vl; v.e_busy = bz; v.e_pc = pc;
        return v;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle.
    task automatic step(input vec_t v, input string nm);
        logic [36:0] got;
        logic [36:0] exp;
        reset                 = v.rst;
        bus.pipe_flush_req    = v.req;
        bus.pipe_flush_pc_op1 = v.op1;
        bus.pipe_flush_pc_op2 = v.op2;
        bus.fetch_cmd_fire    = v.cmd;
        bus.fetch_rsp_fire    = v.rsp;
        bus.pc_redirect_rdy   = v.rdy;
        @(negedge clk);
        got = {bus.pipe_flush_ack, bus.fetch_credit, bus.rsp_discard,
               bus.pc_redirect_vld, bus.flush_busy, bus.pc_redirect_pc};
        exp = {v.e_ack, v.e_cr, v.e_dis, v.e_vld, v.e_busy, v.e_pc};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ack/cr/dis/vld/busy/pc=%b%b%b%b%b/%h want %b%b%b%b%b/%h",
                     nm, got[36], got[35], got[34], got[33], got[32], got[31:0],
                     exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    // Idle-state row: no request, only fetch activity.
    function automatic vec_t idl(input logic c, input logic r,
                                 input logic cr, input logic [31:0] pc);
        return mk(0, 0, 0, 0, c, r, 1, 0, cr, 0, 0, 0, pc);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.pipe_flush_req    = 1'b0;
        bus.pipe_flush_pc_op1 = '0;
        bus.pipe_flush_pc_op2 = '0;
        bus.fetch_cmd_fire    = 1'b0;
        bus.fetch_rsp_fire    = 1'b0;
        bus.pc_redirect_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset values
        tbl.push_back(idl(0, 0, 1, 32'h0));
        // Idle flush: 0x8000_0000 + 0x11 -> 0x8000_0010
        tbl.push_back(mk(0, 1, 32'h8000_0000, 32'h11, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h8000_0000, 32'h11, 0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0010));
        tbl.push_back(mk(0, 1, 32'h8000_0000, 32'h11, 0, 0, 1, 0, 0, 0, 1, 1, 32'h8000_0010));
        tbl.push_back(mk(0, 1, 32'h8000_0000, 32'h11, 0, 0, 1, 1, 0, 0, 0, 1, 32'h8000_0010));
        tbl.push_back(idl(0, 0, 1, 32'h8000_0010));
        // Drain: three fetches in flight, responses in DRAIN cycles 2,4,7
        tbl.push_back(idl(1, 0, 1, 32'h8000_0010));
        tbl.push_back(idl(1, 0, 1, 32'h8000_0010));
        tbl.push_back(idl(1, 0, 1, 32'h8000_0010));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h8000_0010));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 1, 1, 0, 0, 1, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 1, 1, 0, 0, 1, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 1, 1, 0, 0, 1, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h1000));
        tbl.push_back(idl(0, 0, 1, 32'h1000));
        // Backpressure: rdy low 5 REDIR cycles, operands changing
        tbl.push_back(mk(0, 1, 32'h2000_0000, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 1, 32'h1111_1111, 32'h2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h3333_0000, 32'h4, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h4444_0000, 32'h6, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h5555_0000, 32'h8, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h6666_0000, 32'ha, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h7777_0000, 32'hc, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h8888_0000, 32'he, 0, 0, 1, 0, 0, 0, 1, 1, 32'h2000_0100));
        tbl.push_back(mk(0, 1, 32'h9999_0000, 32'h0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h2000_0100));
        tbl.push_back(idl(0, 0, 1, 32'h2000_0100));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Saturation: 5 commands at depth 4, then drain and underflow
        for (int i = 0; i < 5; i++)
            step(idl(1, 0, (i < 4), 32'h2000_0100), $sformatf("sat_cmd%0d", i));
        step(idl(0, 0, 0, 32'h2000_0100), "sat_hold");
        for (int i = 0; i < 4; i++)
            step(idl(0, 1, (i > 0), 32'h2000_0100), $sformatf("sat_rsp%0d", i));
        for (int i = 0; i < 2; i++)
            step(idl(0, 1, 1, 32'h2000_0100), $sformatf("under_rsp%0d", i));
        // Wrap-around target; immediate REDIR proves count is 0
        step(mk(0, 1, 32'hFFFF_FFF0, 32'h24, 0, 0, 1, 0, 1, 0, 0, 0, 32'h2000_0100), "wrap_c0");
        step(mk(0, 1, 32'hFFFF_FFF0, 32'h24, 0, 0, 1, 0, 0, 0, 0, 1, 32'h14), "wrap_c1");
        step(mk(0, 1, 32'hFFFF_FFF0, 32'h24, 0, 0, 1, 0, 0, 0, 1, 1, 32'h14), "wrap_c2");
        step(mk(0, 1, 32'hFFFF_FFF0, 32'h24, 0, 0, 1, 1, 0, 0, 0, 1, 32'h14), "wrap_c3");
        // Back-to-back: req held one cycle past ack
        step(mk(0, 1, 32'h0, 32'h40, 0, 0, 1, 0, 1, 0, 0, 0, 32'h14), "b2b_c4");
        step(mk(0, 1, 32'h0, 32'h40, 0, 0, 1, 0, 0, 0, 0, 1, 32'h40), "b2b_c5");
        step(mk(0, 1, 32'h0, 32'h40, 0, 0, 1, 0, 0, 0, 1, 1, 32'h40), "b2b_c6");
        step(mk(0, 1, 32'h0, 32'h40, 0, 0, 1, 1, 0, 0, 0, 1, 32'h40), "b2b_c7");
        step(idl(0, 0, 1, 32'h40), "b2b_c8");
        // Stray command during DRAIN must be waited for
        step(mk(0, 1, 32'h80, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h40), "stray_c0");
        step(mk(0, 1, 32'h80, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h80), "stray_c1");
        step(mk(0, 1, 32'h80, 0, 0, 1, 1, 0, 0, 1, 0, 1, 32'h80), "stray_c2");
        step(mk(0, 1, 32'h80, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80), "stray_c3");
        step(mk(0, 1, 32'h80, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h80), "stray_c4");
        step(mk(0, 1, 32'h80, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h80), "stray_c5");
        step(idl(0, 0, 1, 32'h80), "stray_c6");
        // Reset mid-DRAIN with two fetches outstanding
        step(idl(1, 0, 1, 32'h80), "rst_cmd0");
        step(idl(1, 0, 1, 32'h80), "rst_cmd1");
        step(mk(0, 1, 32'h300, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h80), "rst_c0");
        step(mk(0, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h300), "rst_c1");
        step(mk(1, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h300), "rst_c2");
        step(idl(0, 0, 1, 32'h0), "rst_c3");
        step(mk(0, 1, 32'h500, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0), "rst_c4");
        step(mk(0, 1, 32'h500, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h500), "rst_c5");
        step(mk(0, 1, 32'h500, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h500), "rst_c6");
        step(mk(0, 1, 32'h500, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h500), "rst_c7");
        step(idl(0, 0, 1, 32'h500), "rst_c8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
